// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - state encodings, grant encoding and sizing constants for mem_arbiter
package mem_arbiter_pkg;

  localparam int BEATS            = 4;
  localparam int DATA_BASE_DEFAULT = 256;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DBEAT,
    ST_IBEAT,
    ST_IGAP,
    ST_ACK
  } state_e;

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } grant_e;

endpackage

// File: rtl/mem_beat_tracker.sv
// rtl/mem_beat_tracker.sv - remembers that memory went busy during a beat and pulses done when it falls
module mem_beat_tracker (
  input  logic CLK,
  input  logic RESET,
  input  logic active,
  input  logic m_busywait,
  output logic done
);

  logic seen_busy_q, seen_busy_d;

  // Outside a beat the flag is forced clear, so each beat starts fresh.
  always_comb begin
    seen_busy_d = active & m_busywait;
    done        = active & seen_busy_q & ~m_busywait;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) seen_busy_q <= 1'b0;
    else        seen_busy_q <= seen_busy_d;
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares one word memory between icache 4-beat refills and dcache single beats
// Round-robin on conflict; define MEM_ARB_DFIRST_EN for fixed D-first priority.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int IADDR_W   = 6,
  parameter int DADDR_W   = 6,
  parameter int MADDR_W   = 9,
  parameter int DATA_BASE = DATA_BASE_DEFAULT
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  i_read,
  input  logic [IADDR_W-1:0]    i_address,
  output logic [32*BEATS-1:0]   i_readdata,
  output logic                  i_busywait,
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [DADDR_W-1:0]    d_address,
  input  logic [31:0]           d_writedata,
  output logic [31:0]           d_readdata,
  output logic                  d_busywait,
  output logic                  m_read,
  output logic                  m_write,
  output logic [MADDR_W-1:0]    m_address,
  output logic [31:0]           m_writedata,
  input  logic [31:0]           m_readdata,
  input  logic                  m_busywait
);

  state_e                state_q, state_d;
  logic                  gnt_d_q, gnt_d_d;
  logic                  wr_q, wr_d;
  logic [IADDR_W-1:0]    i_addr_q, i_addr_d;
  logic [DADDR_W-1:0]    d_addr_q, d_addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [1:0]            beat_q, beat_d;
  logic [32*BEATS-1:0]   i_buf_q, i_buf_d;
  logic [31:0]           d_buf_q, d_buf_d;

  logic d_req, i_req, d_wins, beat_active, done, ack;

  assign d_req       = d_read | d_write;
  assign i_req       = i_read;
  assign beat_active = (state_q == ST_DBEAT) || (state_q == ST_IBEAT);
  assign ack         = (state_q == ST_ACK);

`ifdef MEM_ARB_DFIRST_EN
  assign d_wins = d_req;
`else
  grant_e last_grant_q, last_grant_d;

  assign d_wins = d_req & (~i_req | (last_grant_q == GNT_I));

  always_comb begin
    last_grant_d = last_grant_q;
    if (state_q == ST_IDLE && (d_req || i_req))
      last_grant_d = d_wins ? GNT_D : GNT_I;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) last_grant_q <= GNT_I;
    else        last_grant_q <= last_grant_d;
  end
`endif

  mem_beat_tracker u_tracker (
    .CLK        (CLK),
    .RESET      (RESET),
    .active     (beat_active),
    .m_busywait (m_busywait),
    .done       (done)
  );

  always_comb begin
    state_d  = state_q;
    gnt_d_d  = gnt_d_q;
    wr_d     = wr_q;
    i_addr_d = i_addr_q;
    d_addr_d = d_addr_q;
    wdata_d  = wdata_q;
    beat_d   = beat_q;
    i_buf_d  = i_buf_q;
    d_buf_d  = d_buf_q;
    case (state_q)
      ST_IDLE: begin
        if (d_wins) begin
          state_d  = ST_DBEAT;
          gnt_d_d  = 1'b1;
          wr_d     = d_write;
          d_addr_d = d_address;
          wdata_d  = d_writedata;
        end else if (i_req) begin
          state_d  = ST_IBEAT;
          gnt_d_d  = 1'b0;
          i_addr_d = i_address;
          beat_d   = 2'd0;
        end
      end
      ST_DBEAT: begin
        if (done) begin
          if (!wr_q) d_buf_d = m_readdata;
          state_d = ST_ACK;
        end
      end
      ST_IBEAT: begin
        if (done) begin
          i_buf_d[32*beat_q +: 32] = m_readdata;
          if (beat_q == 2'(BEATS-1)) begin
            state_d = ST_ACK;
          end else begin
            beat_d  = beat_q + 2'd1;
            state_d = ST_IGAP;
          end
        end
      end
      // Memory starts a beat on a strobe edge, so bursts need a low cycle between words.
      ST_IGAP: state_d = ST_IBEAT;
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q  <= ST_IDLE;
      gnt_d_q  <= 1'b0;
      wr_q     <= 1'b0;
      i_addr_q <= '0;
      d_addr_q <= '0;
      wdata_q  <= '0;
      beat_q   <= '0;
      i_buf_q  <= '0;
      d_buf_q  <= '0;
    end else begin
      state_q  <= state_d;
      gnt_d_q  <= gnt_d_d;
      wr_q     <= wr_d;
      i_addr_q <= i_addr_d;
      d_addr_q <= d_addr_d;
      wdata_q  <= wdata_d;
      beat_q   <= beat_d;
      i_buf_q  <= i_buf_d;
      d_buf_q  <= d_buf_d;
    end
  end

  always_comb begin
    m_read    = (state_q == ST_IBEAT) || ((state_q == ST_DBEAT) && !wr_q);
    m_write   = (state_q == ST_DBEAT) && wr_q;
    m_address = '0;
    if (state_q == ST_IBEAT)
      m_address = MADDR_W'({i_addr_q, beat_q});
    else if (state_q == ST_DBEAT)
      m_address = MADDR_W'(DATA_BASE) + MADDR_W'(d_addr_q);
  end

  assign m_writedata = wdata_q;
  assign i_readdata  = i_buf_q;
  assign d_readdata  = d_buf_q;
  assign i_busywait  = RESET & i_read & ~(ack & ~gnt_d_q);
  assign d_busywait  = RESET & d_req  & ~(ack &  gnt_d_q);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter with a behavioural memory and reference model
module tb_mem_arbiter;

  logic         CLK = 1'b0;
  logic         RESET = 1'b0;
  logic         i_read = 1'b0;
  logic [5:0]   i_address = '0;
  logic [127:0] i_readdata;
  logic         i_busywait;
  logic         d_read = 1'b0;
  logic         d_write = 1'b0;
  logic [5:0]   d_address = '0;
  logic [31:0]  d_writedata = '0;
  logic [31:0]  d_readdata;
  logic         d_busywait;
  logic         m_read, m_write;
  logic [8:0]   m_address;
  logic [31:0]  m_writedata;
  logic [31:0]  m_readdata;
  logic         m_busywait;

  always #5 CLK = ~CLK;

  mem_arbiter dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .i_read      (i_read),
    .i_address   (i_address),
    .i_readdata  (i_readdata),
    .i_busywait  (i_busywait),
    .d_read      (d_read),
    .d_write     (d_write),
    .d_address   (d_address),
    .d_writedata (d_writedata),
    .d_readdata  (d_readdata),
    .d_busywait  (d_busywait),
    .m_read      (m_read),
    .m_write     (m_write),
    .m_address   (m_address),
    .m_writedata (m_writedata),
    .m_readdata  (m_readdata),
    .m_busywait  (m_busywait)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Memory: a beat starts on a rising strobe, stays busy 1..3 cycles, then completes.
  logic [31:0] img   [0:511];
  logic [31:0] mem   [0:511];
  logic [31:0] ref_d [0:63];
  logic        busy = 1'b0, prev = 1'b0, mem_init = 1'b0, wr_l = 1'b0;
  int          cnt = 0;
  logic [8:0]  addr_l = '0, last_waddr = '0;
  logic [31:0] wdata_l = '0, last_wdata = '0, rdata = '0;
  int          start_log[$];

  assign m_busywait = busy;
  assign m_readdata = rdata;

  always @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      busy <= 1'b0;
      prev <= 1'b0;
      cnt  <= 0;
      if (!mem_init) begin
        for (int k = 0; k < 512; k++) mem[k] <= img[k];
        mem_init <= 1'b1;
      end
    end else begin
      prev <= m_read | m_write;
      if (busy) begin
        if (cnt <= 1) begin
          busy <= 1'b0;
          if (wr_l) begin
            mem[addr_l] <= wdata_l;
            last_waddr  <= addr_l;
            last_wdata  <= wdata_l;
          end else begin
            rdata <= mem[addr_l];
          end
        end else begin
          cnt <= cnt - 1;
        end
      end else if ((m_read || m_write) && !prev) begin
        busy    <= 1'b1;
        cnt     <= int'($urandom_range(1, 3));
        addr_l  <= m_address;
        wr_l    <= m_write;
        wdata_l <= m_writedata;
        start_log.push_back(int'(m_address));
      end
    end
  end

  typedef struct {
    logic        rd;
    logic [31:0] data;
  } dexp_t;

  logic [127:0] i_exp[$];
  dexp_t        d_exp[$];
  byte          ack_order[$];

  always @(negedge CLK) begin
    logic [127:0] ie;
    dexp_t        de;
    if (RESET) begin
      if (i_read && !i_busywait) begin
        ack_order.push_back("I");
        if (i_exp.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL i_ack_unexpected: got ack expected none");
        end else begin
          ie = i_exp.pop_front();
          chk("i_readdata", i_readdata, ie);
        end
      end
      if ((d_read || d_write) && !d_busywait) begin
        ack_order.push_back("D");
        if (d_exp.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL d_ack_unexpected: got ack expected none");
        end else begin
          de = d_exp.pop_front();
          if (de.rd) chk("d_readdata", {96'd0, d_readdata}, {96'd0, de.data});
        end
      end
    end
  end

  task automatic wait_i_ack();
    int n = 0;
    forever begin
      @(negedge CLK);
      if (!i_busywait) break;
      if (++n > 3000) begin
        n_cmp++; n_err++;
        $display("FAIL i_ack_timeout: got no ack expected ack within 3000 cycles");
        break;
      end
    end
  endtask

  task automatic wait_d_ack();
    int n = 0;
    forever begin
      @(negedge CLK);
      if (!d_busywait) break;
      if (++n > 3000) begin
        n_cmp++; n_err++;
        $display("FAIL d_ack_timeout: got no ack expected ack within 3000 cycles");
        break;
      end
    end
  endtask

  // Drivers are entered and left at posedge+1.
  task automatic i_txn(input logic [5:0] a);
    logic [127:0] e;
    for (int k = 0; k < 4; k++) e[32*k +: 32] = img[int'(a)*4 + k];
    i_exp.push_back(e);
    i_read = 1'b1;
    i_address = a;
    wait_i_ack();
    @(posedge CLK); #1;
    i_read = 1'b0;
  endtask

  task automatic d_txn(input logic wr, input logic [5:0] a, input logic [31:0] wd);
    dexp_t e;
    if (wr) begin
      ref_d[a] = wd;
      e.rd = 1'b0;
      e.data = '0;
    end else begin
      e.rd = 1'b1;
      e.data = ref_d[a];
    end
    d_exp.push_back(e);
    d_write = wr;
    d_read = wr ? 1'($urandom_range(0, 1)) : 1'b1;
    d_address = a;
    d_writedata = wd;
    wait_d_ack();
    @(posedge CLK); #1;
    d_read = 1'b0;
    d_write = 1'b0;
  endtask

  task automatic idle(input int g);
    repeat (g) begin @(posedge CLK); #1; end
  endtask

  initial begin
    logic [5:0] a;
    int n;
    for (int k = 0; k < 512; k++) img[k] = $urandom;
    for (int k = 0; k < 64; k++) ref_d[k] = img[256 + k];

    i_read = 1'b1;
    d_read = 1'b1;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("rst_i_readdata", i_readdata, 128'd0);
    chk("rst_d_readdata", {96'd0, d_readdata}, 128'd0);
    chk("rst_m_read", {127'd0, m_read}, 128'd0);
    chk("rst_m_write", {127'd0, m_write}, 128'd0);
    chk("rst_m_address", {119'd0, m_address}, 128'd0);
    chk("rst_i_busywait", {127'd0, i_busywait}, 128'd0);
    chk("rst_d_busywait", {127'd0, d_busywait}, 128'd0);
    i_read = 1'b0;
    d_read = 1'b0;
    RESET = 1'b1;
    idle(1);

    // Single D write
    start_log.delete();
    ref_d[5] = 32'hA5A5A5A5;
    d_exp.push_back('{1'b0, 32'd0});
    d_write = 1'b1; d_address = 6'd5; d_writedata = 32'hA5A5A5A5;
    wait_d_ack();
    chk("dw_addr", {119'd0, last_waddr}, 128'd261);
    chk("dw_data", {96'd0, last_wdata}, {96'd0, 32'hA5A5A5A5});
    chk("dw_starts", start_log.size(), 1);
    @(negedge CLK);
    chk("dw_busy_back", {127'd0, d_busywait}, 128'd1);
    d_write = 1'b0;
    idle(2);

    // Single I refill of block 2
    start_log.delete();
    i_txn(6'd2);
    chk("ir_starts", start_log.size(), 4);
    for (int k = 0; k < 4; k++) chk("ir_beat_addr", start_log[k], 8 + k);
    idle(2);

    // Conflict, then D re-requests while I is still pending
    ack_order.delete();
    a = 6'($urandom);
    fork
      i_txn(a);
      begin
        d_txn(1'b0, 6'($urandom), 32'd0);
        d_txn(1'b0, 6'($urandom), 32'd0);
      end
    join
    chk("cf_count", ack_order.size(), 3);
`ifdef MEM_ARB_DFIRST_EN
    chk("cf_first", ack_order[0], "D");
    chk("cf_second", ack_order[1], "D");
    chk("cf_third", ack_order[2], "I");
`else
    chk("cf_first", ack_order[0], "D");
    chk("cf_second", ack_order[1], "I");
    chk("cf_third", ack_order[2], "D");
`endif
    idle(2);

    // D read dropped mid-beat; queued I refill must still be served
    ack_order.delete();
    fork
      begin
        d_read = 1'b1; d_address = 6'd7;
        n = 0;
        forever begin
          @(negedge CLK);
          if (m_read && m_address == 9'd263) break;
          if (++n > 100) begin
            n_cmp++; n_err++;
            $display("FAIL drop_grant_timeout: got no D beat expected beat at 263");
            break;
          end
        end
        @(posedge CLK); #1;
        d_read = 1'b0;
      end
      begin
        idle(1);
        i_txn(6'd9);
      end
    join
    chk("drop_acks", ack_order.size(), 1);
    chk("drop_ack_side", ack_order[0], "I");
    idle(2);

    // Reset during beat 2 of a refill
    start_log.delete();
    a = 6'($urandom);
    i_read = 1'b1; i_address = a;
    n = 0;
    forever begin
      @(negedge CLK);
      if (start_log.size() == 3) break;
      if (++n > 200) begin
        n_cmp++; n_err++;
        $display("FAIL rstmid_timeout: got %0d beats expected 3", start_log.size());
        break;
      end
    end
    RESET = 1'b0;
    #1;
    chk("rstmid_m_read", {127'd0, m_read}, 128'd0);
    chk("rstmid_m_write", {127'd0, m_write}, 128'd0);
    chk("rstmid_i_busywait", {127'd0, i_busywait}, 128'd0);
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RESET = 1'b1;
    i_read = 1'b0;
    idle(1);
    start_log.delete();
    i_txn(a);
    chk("rstmid_refetch_beats", start_log.size(), 4);
    chk("rstmid_refetch_first", start_log[0], int'(a) * 4);
    idle(2);

    // Random concurrent traffic
    fork
      for (int t = 0; t < 25; t++) begin
        i_txn(6'($urandom));
        idle(int'($urandom_range(0, 3)));
      end
      for (int t = 0; t < 40; t++) begin
        d_txn(1'($urandom), 6'($urandom), $urandom);
        idle(int'($urandom_range(0, 3)));
      end
    join
    idle(10);

    chk("end_i_queue", i_exp.size(), 0);
    chk("end_d_queue", d_exp.size(), 0);
    for (int k = 0; k < 64; k++) chk("end_data_region", {96'd0, mem[256 + k]}, {96'd0, ref_d[k]});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
